div_share_arbiter: RTL and testbench
====================================

# div_share_arbiter

Arbiter and sequencer that shares one iterative divider between the scalar execute stage (DIV/DIVU/REM/REMU) and the vector unit (vdiv/vdivu/vrem/vremu element ops). It owns the divider's start/done handshake, grants requesters round-robin, returns each result to its owner with valid/ready back-pressure, and drops results of killed scalar operations. It sits between the execute stage, the vector lane and the shared divider.

## Interface
- DATA_WIDTH, 32, operand/result width
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- s_req_valid  in  1  scalar request valid
- s_req_ready  out  1  scalar request accepted this cycle
- s_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- s_op_a / s_op_b  in  DATA_WIDTH  scalar dividend / divisor
- s_kill  in  1  flush of the scalar pipeline; discards the scalar op
- s_resp_valid  out  1  scalar result valid
- s_resp_data  out  DATA_WIDTH  scalar result
- s_resp_ready  in  1  scalar consumer accepts result
- v_req_valid, v_req_ready, v_op, v_op_a, v_op_b, v_resp_valid, v_resp_data, v_resp_ready: same widths and meanings for the vector requester; no kill
- div_start  out  1  one-cycle start pulse to divider
- div_op  out  2  op code to divider, s_op encoding
- div_a / div_b  out  DATA_WIDTH  registered operands
- div_done  in  1  divider result valid, one-cycle pulse
- div_result  in  DATA_WIDTH  divider result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, START, BUSY, RESP. Registers: owner (S/V), last_grant (S/V), op, operands, result.
- IDLE: s_req_ready = !s_kill && (!v_req_valid || last_grant==V); v_req_ready = !s_req_ready || !s_req_valid. This means the requester not granted last wins ties, and a lone valid requester always wins. On handshake: latch op/operands, set owner and last_grant, go to START.
- START: div_start=1 for exactly this cycle; div_op/div_a/div_b are driven from the registers and held constant until the divider completes. Go to BUSY.
- BUSY: wait for div_done. On div_done, latch div_result and go to RESP. If the op is killed, go to IDLE instead.
- RESP: the owner's resp_valid=1 with resp_data stable. On owner resp_ready, go to IDLE. The other requester's resp_valid stays 0.
- Kill (owner S only): s_kill in START or BUSY sets a killed flag. The divider still runs to div_done, then the FSM returns to IDLE with no s_resp_valid. s_kill in RESP forces IDLE next cycle with no handshake. s_kill has no effect when owner=V.
- Requests are never accepted outside IDLE. Both req_ready are 0 in START/BUSY/RESP.
- div_done outside BUSY is ignored.

## Timing
- Reset: state IDLE, last_grant=V, owner=S, killed=0. div_start, s_resp_valid, v_resp_valid and busy are 0. div_op, div_a, div_b, s_resp_data and v_resp_data are 0.
- Accept in cycle T: div_start in T+1, BUSY from T+2.
- div_done in cycle D: resp_valid from D+1. With resp_ready=1 in D+1, the FSM is IDLE in D+2.
- Minimum request-to-request throughput: divider latency + 3 cycles.
- Reset asserted mid-operation: immediate return to reset values. A div_done arriving after release is ignored (state IDLE).

## Configuration
- DIV_ZERO_BYPASS_EN defined:
  - An accepted request with op_b==0 skips START/BUSY and goes directly to RESP at T+1.
  - Result: DIV/DIVU give all ones; REM/REMU give op_a.
  - div_start is not pulsed, and kill rules for RESP apply.
- Undefined: zero divisors go through the divider like any other operand.

## Test plan
- Scalar DIV 100/7, divider model latency 34: accept T -> div_start T+1 only, div_done T+35, s_resp_valid T+36 with s_resp_data=14, busy=0 at T+37.
- s_req_valid and v_req_valid both held from reset, operands 9/3 and 20/4: scalar served first (3), vector second (5). Re-requesting both while last_grant=V serves scalar first.
- s_kill one cycle in BUSY (DIVU 50/5): no s_resp_valid, FSM IDLE after div_done, pending v request accepted that cycle.
- v REMU 17/5 with v_resp_ready=0 for 5 cycles: v_resp_valid=1 and v_resp_data=2 stable throughout, s_req_ready=0 throughout, IDLE one cycle after ready.
- Macro defined, v REM 0xFFFFFFF9/0: v_resp_valid at T+1 with data 0xFFFFFFF9, div_start never asserted. Macro undefined: div_start at T+1 with div_b=0.
- reset_n low during BUSY, then div_done pulsed after release: all outputs at reset values, no resp_valid, next request handled normally.

Source files
------------

// File: rtl/div_share_arbiter.sv
// Shares one iterative divider between the scalar execute stage and the vector unit (optional DIV_ZERO_BYPASS_EN).
// Latency: accept T -> div_start T+1; div_done D -> resp_valid D+1 (bypass: zero divisor answered at T+1).
// Backpressure: one op in flight; both req_ready low outside IDLE, result held until the owner's resp_ready.
module div_share_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_req_valid,
  output logic                  s_req_ready,
  input  logic [1:0]            s_op,
  input  logic [DATA_WIDTH-1:0] s_op_a,
  input  logic [DATA_WIDTH-1:0] s_op_b,
  input  logic                  s_kill,
  output logic                  s_resp_valid,
  output logic [DATA_WIDTH-1:0] s_resp_data,
  input  logic                  s_resp_ready,
  input  logic                  v_req_valid,
  output logic                  v_req_ready,
  input  logic [1:0]            v_op,
  input  logic [DATA_WIDTH-1:0] v_op_a,
  input  logic [DATA_WIDTH-1:0] v_op_b,
  output logic                  v_resp_valid,
  output logic [DATA_WIDTH-1:0] v_resp_data,
  input  logic                  v_resp_ready,
  output logic                  div_start,
  output logic [1:0]            div_op,
  output logic [DATA_WIDTH-1:0] div_a,
  output logic [DATA_WIDTH-1:0] div_b,
  input  logic                  div_done,
  input  logic [DATA_WIDTH-1:0] div_result,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;
  typedef enum logic {OWN_S = 1'b0, OWN_V = 1'b1} who_t;

  typedef struct packed {
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } req_t;

  state_t                state;
  who_t                  owner;
  who_t                  last_grant;
  req_t                  req_q;
  logic                  killed;
  logic [DATA_WIDTH-1:0] result;

  logic                  s_win;
  logic                  s_take;
  logic                  v_take;
  logic                  kill_hit;
  logic                  owner_ready;
  req_t                  new_req;

  // Scalar wins unless the vector side is waiting and was not the last one served.
  always_comb begin
    s_win       = !s_kill && (!v_req_valid || last_grant == OWN_V);
    s_req_ready = (state == IDLE) && s_win;
    v_req_ready = (state == IDLE) && (!s_win || !s_req_valid);
    s_take      = s_req_valid && s_req_ready;
    v_take      = v_req_valid && v_req_ready;
    new_req.op  = s_take ? s_op   : v_op;
    new_req.a   = s_take ? s_op_a : v_op_a;
    new_req.b   = s_take ? s_op_b : v_op_b;
    kill_hit    = s_kill && (owner == OWN_S);
    owner_ready = (owner == OWN_S) ? s_resp_ready : v_resp_ready;
  end

`ifdef DIV_ZERO_BYPASS_EN
  logic                  zero_div;
  logic [DATA_WIDTH-1:0] zero_result;

  always_comb begin
    zero_div    = (new_req.b == '0);
    zero_result = new_req.op[1] ? new_req.a : '1;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      owner        <= OWN_S;
      last_grant   <= OWN_V;
      killed       <= 1'b0;
      req_q        <= '0;
      result       <= '0;
      div_start    <= 1'b0;
      s_resp_valid <= 1'b0;
      v_resp_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (s_take || v_take) begin
            req_q      <= new_req;
            owner      <= s_take ? OWN_S : OWN_V;
            last_grant <= s_take ? OWN_S : OWN_V;
            killed     <= 1'b0;
            busy       <= 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
            if (zero_div) begin
              result       <= zero_result;
              s_resp_valid <= s_take;
              v_resp_valid <= v_take;
              state        <= RESP;
            end else begin
              div_start <= 1'b1;
              state     <= START;
            end
`else
            div_start <= 1'b1;
            state     <= START;
`endif
          end
        end
        START: begin
          if (kill_hit) killed <= 1'b1;
          state <= BUSY;
        end
        BUSY: begin
          if (kill_hit) killed <= 1'b1;
          // A killed op still has to drain the divider before it can be reused.
          if (div_done) begin
            if (killed || kill_hit) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              result       <= div_result;
              s_resp_valid <= (owner == OWN_S);
              v_resp_valid <= (owner == OWN_V);
              state        <= RESP;
            end
          end
        end
        RESP: begin
          if (kill_hit || owner_ready) begin
            s_resp_valid <= 1'b0;
            v_resp_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign div_op      = req_q.op;
  assign div_a       = req_q.a;
  assign div_b       = req_q.b;
  assign s_resp_data = result;
  assign v_resp_data = result;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: divider model plus scoreboard of architectural div/rem results.
module tb_div_share_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         s_req_valid = 1'b0;
  logic         s_req_ready;
  logic [1:0]   s_op = 2'd0;
  logic [W-1:0] s_op_a = '0;
  logic [W-1:0] s_op_b = '0;
  logic         s_kill = 1'b0;
  logic         s_resp_valid;
  logic [W-1:0] s_resp_data;
  logic         s_resp_ready = 1'b1;
  logic         v_req_valid = 1'b0;
  logic         v_req_ready;
  logic [1:0]   v_op = 2'd0;
  logic [W-1:0] v_op_a = '0;
  logic [W-1:0] v_op_b = '0;
  logic         v_resp_valid;
  logic [W-1:0] v_resp_data;
  logic         v_resp_ready = 1'b1;
  logic         div_start;
  logic [1:0]   div_op;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic         div_done = 1'b0;
  logic [W-1:0] div_result = '0;
  logic         busy;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           lat = 34;
  bit           lat_rand = 1'b0;
  logic [W-1:0] s_q[$];
  logic [W-1:0] v_q[$];
  bit           s_out = 1'b0;
  bit           v_out = 1'b0;
  bit           mlast_v = 1'b1;
  bit           prev_start = 1'b0;
  int           s_acc_cyc = 0;
  int           v_acc_cyc = 0;
  int           done_cyc = 0;
  int           n_starts = 0;
  int           n_s_resp = 0;
  logic [1:0]   dm_op;
  logic [W-1:0] dm_a;
  logic [W-1:0] dm_b;
  int           dm_lat;

  div_share_arbiter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_op(s_op),
    .s_op_a(s_op_a), .s_op_b(s_op_b), .s_kill(s_kill),
    .s_resp_valid(s_resp_valid), .s_resp_data(s_resp_data), .s_resp_ready(s_resp_ready),
    .v_req_valid(v_req_valid), .v_req_ready(v_req_ready), .v_op(v_op),
    .v_op_a(v_op_a), .v_op_b(v_op_b),
    .v_resp_valid(v_resp_valid), .v_resp_data(v_resp_data), .v_resp_ready(v_resp_ready),
    .div_start(div_start), .div_op(div_op), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_result(div_result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT (cycle %0d)", name, cyc);
  endtask

  // RISC-V M-extension semantics, including divide-by-zero and signed overflow.
  function automatic logic [W-1:0] ref_div(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == '1);
    if (b == '0) return op[1] ? a : '1;
    case (op)
      2'd0:    return ovf ? a : $signed(a) / $signed(b);
      2'd1:    return a / b;
      2'd2:    return ovf ? '0 : $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Shared divider: answers each start after dm_lat cycles, garbage on the result bus otherwise.
  always begin
    @(negedge clk);
    if (!div_done) div_result = $urandom;
    if (reset_n && div_start) begin
      dm_op  = div_op;
      dm_a   = div_a;
      dm_b   = div_b;
      dm_lat = lat_rand ? int'($urandom_range(1, 12)) : lat;
      repeat (dm_lat) @(posedge clk);
      #1;
      if (busy) begin
        chk("div_operands_held", {div_op, div_a}, {dm_op, dm_a});
        chk("div_divisor_held", div_b, dm_b);
      end
      div_done   = 1'b1;
      div_result = ref_div(dm_op, dm_a, dm_b);
      done_cyc   = cyc;
      @(posedge clk);
      #1;
      div_done = 1'b0;
    end
  end

  // Scoreboard: push expectation at request handshake, pop at response handshake or kill.
  always @(negedge clk) begin
    if (!reset_n) begin
      s_q.delete();
      v_q.delete();
      s_out      = 1'b0;
      v_out      = 1'b0;
      mlast_v    = 1'b1;
      prev_start = 1'b0;
    end else begin
      if (div_start) begin
        n_starts++;
        chk("div_start_one_cycle", 64'(prev_start), 64'd0);
      end
      prev_start = div_start;
      if ((s_req_valid && s_req_ready) || (v_req_valid && v_req_ready)) begin
        chk("one_grant", 64'((s_req_valid && s_req_ready) && (v_req_valid && v_req_ready)), 64'd0);
        chk("accept_only_when_free", {s_out, v_out}, 2'b00);
        if (s_req_valid && v_req_valid && !s_kill)
          chk("round_robin_s_wins", 64'(s_req_ready), 64'(mlast_v));
        if (s_req_valid && s_req_ready) begin
          chk("no_accept_during_kill", 64'(s_kill), 64'd0);
          s_q.push_back(ref_div(s_op, s_op_a, s_op_b));
          s_out     = 1'b1;
          mlast_v   = 1'b0;
          s_acc_cyc = cyc;
        end else begin
          v_q.push_back(ref_div(v_op, v_op_a, v_op_b));
          v_out     = 1'b1;
          mlast_v   = 1'b1;
          v_acc_cyc = cyc;
        end
      end
      if (s_resp_valid || v_resp_valid)
        chk("resp_exclusive", 64'(s_resp_valid && v_resp_valid), 64'd0);
      if (s_resp_valid && s_resp_ready) begin
        n_s_resp++;
        if (s_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL s_resp_unexpected: got %h expected no response (cycle %0d)", s_resp_data, cyc);
        end else chk("s_resp_data", s_resp_data, s_q.pop_front());
        s_out = 1'b0;
      end else if (s_kill && s_out) begin
        if (s_q.size() != 0) void'(s_q.pop_front());
        s_out = 1'b0;
      end
      if (v_resp_valid && v_resp_ready) begin
        if (v_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL v_resp_unexpected: got %h expected no response (cycle %0d)", v_resp_data, cyc);
        end else chk("v_resp_data", v_resp_data, v_q.pop_front());
        v_out = 1'b0;
      end
    end
  end

  task automatic issue_s(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 1'b0;
    s_req_valid = 1'b1; s_op = op; s_op_a = a; s_op_b = b;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = s_req_ready;
      @(posedge clk);
      #1;
    end
    s_req_valid = 1'b0;
    if (!ok) fail_timeout("s_accept");
  endtask

  task automatic issue_v(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 1'b0;
    v_req_valid = 1'b1; v_op = op; v_op_a = a; v_op_b = b;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = v_req_ready;
      @(posedge clk);
      #1;
    end
    v_req_valid = 1'b0;
    if (!ok) fail_timeout("v_accept");
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || s_q.size() != 0 || v_q.size() != 0) && n < 2000);
    if (busy || s_q.size() != 0 || v_q.size() != 0) fail_timeout(name);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_ctl"}, {busy, div_start, s_resp_valid, v_resp_valid, div_op}, '0);
    chk({name, "_ab"}, {div_a, div_b}, '0);
    chk({name, "_data"}, {s_resp_data, v_resp_data}, '0);
  endtask

  initial begin
    int ns0, s0, nw, rel_cyc;
    bit s_fin, v_fin;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk_reset("reset");
    chk("reset_ready", {s_req_ready, v_req_ready}, 2'b11);

    // Scalar DIV 100/7 through a 34-cycle divider.
    @(posedge clk); #1;
    lat = 34;
    s_req_valid = 1'b1; s_op = 2'd0; s_op_a = 32'd100; s_op_b = 32'd7;
    @(negedge clk);
    chk("t1_accept", 64'(s_req_ready), 64'd1);
    for (int k = 1; k <= 37; k++) begin
      @(posedge clk); #1;
      s_req_valid = 1'b0;
      @(negedge clk);
      chk("t1_timing", {div_start, s_resp_valid, busy}, {k == 1, k == 36, k <= 36});
      if (k == 1) begin
        chk("t1_div_ab", {div_a, div_b}, {32'd100, 32'd7});
        chk("t1_div_op", 64'(div_op), 64'd0);
      end
    end
    @(posedge clk); #1;
    wait_idle("t1_idle");

    // Both requesters valid out of reset: scalar first, then vector, then scalar again.
    lat = 6;
    s_req_valid = 1'b1; v_req_valid = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    fork
      issue_s(2'd0, 32'd9, 32'd3);
      issue_v(2'd0, 32'd20, 32'd4);
    join
    chk("t2_scalar_first", 64'(v_acc_cyc > s_acc_cyc), 64'd1);
    wait_idle("t2_idle_a");
    fork
      issue_s(2'd1, 32'd81, 32'd9);
      issue_v(2'd3, 32'd81, 32'd10);
    join
    chk("t2_scalar_first_again", 64'(v_acc_cyc > s_acc_cyc), 64'd1);
    wait_idle("t2_idle_b");

    // Kill in BUSY, pending vector op picked up right after div_done, then held response.
    lat = 10; v_resp_ready = 1'b0; ns0 = n_s_resp;
    issue_s(2'd1, 32'd50, 32'd5);
    fork
      issue_v(2'd3, 32'd17, 32'd5);
      begin
        @(posedge clk); #1 s_kill = 1'b1;
        @(posedge clk); #1 s_kill = 1'b0;
      end
    join
    chk("t3_v_accept_after_done", 64'(v_acc_cyc), 64'(done_cyc + 1));
    nw = 0;
    do begin
      @(negedge clk);
      nw++;
    end while (!v_resp_valid && nw < 100);
    if (!v_resp_valid) fail_timeout("t4_v_resp_valid");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(posedge clk); @(negedge clk); end
      chk("t4_hold", {v_resp_valid, s_req_ready, v_resp_data}, {1'b1, 1'b0, 32'd2});
    end
    @(posedge clk); #1 v_resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_idle_after_ready", 64'(busy), 64'd0);
    chk("t3_no_s_resp", 64'(n_s_resp), 64'(ns0));
    @(posedge clk); #1;
    wait_idle("t4_idle");

    // Zero divisor on the vector side.
    s0 = n_starts;
    issue_v(2'd2, 32'hFFFF_FFF9, 32'd0);
    @(negedge clk);
`ifdef DIV_ZERO_BYPASS_EN
    chk("t5_bypass_resp", {v_resp_valid, div_start, v_resp_data}, {1'b1, 1'b0, 32'hFFFF_FFF9});
    @(posedge clk); #1;
    wait_idle("t5_idle");
    chk("t5_no_div_start", 64'(n_starts), 64'(s0));
`else
    chk("t5_start_zero_b", {div_start, div_b}, {1'b1, 32'd0});
    @(posedge clk); #1;
    wait_idle("t5_idle");
    chk("t5_one_div_start", 64'(n_starts), 64'(s0 + 1));
`endif

    // Reset during BUSY; the stale div_done after release must be ignored.
    lat = 20;
    issue_s(2'd0, 32'd100, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #1 reset_n = 1'b0;
    @(negedge clk);
    chk_reset("t6_reset_mid");
    @(posedge clk); #1 reset_n = 1'b1;
    rel_cyc = cyc;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      chk("t6_ignore_done", {busy, s_resp_valid, v_resp_valid, div_start}, 4'b0000);
    end
    chk("t6_done_pulsed", 64'(done_cyc > rel_cyc), 64'd1);
    @(posedge clk); #1;
    issue_v(2'd1, 32'd1000, 32'd10);
    wait_idle("t6_idle");

    // Randomized traffic with random kills and response back-pressure.
    lat_rand = 1'b1; s_fin = 1'b0; v_fin = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          issue_s(2'($urandom_range(0, 3)), rnd_opnd(), rnd_opnd());
        end
        s_fin = 1'b1;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          issue_v(2'($urandom_range(0, 3)), rnd_opnd(), rnd_opnd());
        end
        v_fin = 1'b1;
      end
      begin
        while (!(s_fin && v_fin)) begin
          @(posedge clk); #1;
          s_kill       = ($urandom_range(0, 29) == 0);
          s_resp_ready = !s_kill && ($urandom_range(0, 3) != 0);
          v_resp_ready = ($urandom_range(0, 3) != 0);
        end
        s_kill = 1'b0; s_resp_ready = 1'b1; v_resp_ready = 1'b1;
      end
    join
    wait_idle("rand_idle");
    chk("final_queues_empty", 64'(s_q.size() + v_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
